score_packet_tx: RTL and testbench

Game-state telemetry transmitter: on request, snapshots the current score, bird vertical position and game flags, frames them into a 7-byte packet with an XOR checksum, and feeds the bytes one at a time to the UART transmitter's byte interface. It sits between the game logic (bird control FSM and frame counter) and `UART_TX`, opposite the existing `UART_RX` command path. It gives a host PC a live view of the game.

---
 rtl/score_packet_tx.sv | 180 ++++++++++++++++++
 tb/tb_score_packet_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_packet_tx.sv
// Game telemetry framer: snapshots score, bird Y and flags into a 7-byte packet
// (header, five data bytes, XOR checksum) and hands it byte by byte to UART_TX.
module score_packet_tx #(
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         Y_WIDTH      = 10,
    parameter int         TIMEOUT_CLKS = 5000
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Send,
    input  logic [15:0]        i_Score,
    input  logic [Y_WIDTH-1:0] i_Bird_Y,
    input  logic               i_Dead,
    input  logic               i_Start,
    input  logic               i_TX_Active,
    input  logic               i_TX_Done,
    output logic               o_TX_DV,
    output logic [7:0]         o_TX_Byte,
    output logic               o_Busy,
    output logic               o_Pkt_Done,
    output logic               o_Error,
    output logic [7:0]         o_Drop_Count
);

    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_index;
    logic [2:0]       w_index_next;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic             r_tx_dv;
    logic             w_tx_dv_next;
    logic [7:0]       r_tx_byte;
    logic [7:0]       w_tx_byte_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_pkt_done;
    logic             w_pkt_done_next;
    logic             r_error;
    logic             w_error_next;
    logic [7:0]       r_drop_count;
    logic [7:0]       w_drop_next;
    logic             w_latch;
    logic             w_done_valid;

    logic [7:0]       r_pkt [0:6];
    logic [7:0]       w_fields [0:6];
    logic [15:0]      w_y_ext;
    logic [7:0]       w_cur_byte;

    assign w_y_ext     = 16'(i_Bird_Y);
    assign w_fields[0] = HEADER;
    assign w_fields[1] = i_Score[15:8];
    assign w_fields[2] = i_Score[7:0];
    assign w_fields[3] = w_y_ext[15:8];
    assign w_fields[4] = w_y_ext[7:0];
    assign w_fields[5] = {6'b0, i_Start, i_Dead};
    // Header is deliberately left out of the checksum.
    assign w_fields[6] = w_fields[1] ^ w_fields[2] ^ w_fields[3] ^ w_fields[4] ^ w_fields[5];

    always_comb begin
        case (r_index)
            3'd0:    w_cur_byte = r_pkt[0];
            3'd1:    w_cur_byte = r_pkt[1];
            3'd2:    w_cur_byte = r_pkt[2];
            3'd3:    w_cur_byte = r_pkt[3];
            3'd4:    w_cur_byte = r_pkt[4];
            3'd5:    w_cur_byte = r_pkt[5];
            3'd6:    w_cur_byte = r_pkt[6];
            default: w_cur_byte = 8'h00;
        endcase
    end

    // A Done arriving while our strobe is still up belongs to an earlier byte.
    assign w_done_valid = i_TX_Done & ~r_tx_dv;

    always_comb begin
        w_state_next    = r_state;
        w_index_next    = r_index;
        w_timer_next    = r_timer;
        w_tx_dv_next    = 1'b0;
        w_tx_byte_next  = r_tx_byte;
        w_pkt_done_next = 1'b0;
        w_error_next    = 1'b0;
        w_latch         = 1'b0;
        w_drop_next     = r_drop_count;

        if (r_state != S_IDLE && i_Send && r_drop_count != 8'hFF) begin
            w_drop_next = r_drop_count + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_Send) begin
                    w_latch      = 1'b1;
                    w_index_next = 3'd0;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_TX_Active) begin
                    w_tx_dv_next   = 1'b1;
                    w_tx_byte_next = w_cur_byte;
                    w_timer_next   = '0;
                    w_state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_timer_next = r_timer + CNT_W'(1);
                if (w_done_valid) begin
                    if (r_index == 3'd6) begin
                        w_pkt_done_next = 1'b1;
                        w_state_next    = S_IDLE;
                    end else begin
                        w_index_next = r_index + 3'd1;
                        w_state_next = S_ISSUE;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_error_next = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state      <= S_IDLE;
            r_index      <= 3'd0;
            r_timer      <= '0;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_busy       <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_error      <= 1'b0;
            r_drop_count <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_index      <= w_index_next;
            r_timer      <= w_timer_next;
            r_tx_dv      <= w_tx_dv_next;
            r_tx_byte    <= w_tx_byte_next;
            r_busy       <= w_busy_next;
            r_pkt_done   <= w_pkt_done_next;
            r_error      <= w_error_next;
            r_drop_count <= w_drop_next;
        end
    end

    // Snapshot register: all fields captured in the same cycle as the request.
    always_ff @(posedge i_Clk) begin
        if (w_latch) begin
            for (int i = 0; i < 7; i++) begin
                r_pkt[i] <= w_fields[i];
            end
        end
    end

    assign o_TX_DV      = r_tx_dv;
    assign o_TX_Byte    = r_tx_byte;
    assign o_Busy       = r_busy;
    assign o_Pkt_Done   = r_pkt_done;
    assign o_Error      = r_error;
    assign o_Drop_Count = r_drop_count;

endmodule

// File: tb/tb_score_packet_tx.sv
// Directed bench for score_packet_tx: UART_TX behavioural model, byte scoreboard,
// drop counting, busy-TX stall, back-to-back packets, reset abort and timeout.
module tb_score_packet_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, send, dead, start;
    logic [15:0] score;
    logic [9:0]  bird_y;
    logic        model_act, tx_hold, tx_done, tx_active;
    logic        dv, done_p, busy, err;
    logic [7:0]  tx_byte, drops;

    logic        send2, act2, done2;
    logic        dv2, pdone2, busy2, err2;
    logic [7:0]  byte2, drops2;

    assign tx_active = model_act | tx_hold;

    int tests = 0;
    int failed = 0;
    int bit_clks = 217;
    int n_strobes = 0;
    logic [7:0] exp_q [$];
    logic [7:0] nominal_tbl [7] = '{8'hA5, 8'h01, 8'h23, 8'h00, 8'hF0, 8'h02, 8'hD0};

    score_packet_tx #(.HEADER(8'hA5), .Y_WIDTH(10), .TIMEOUT_CLKS(5000)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Send(send), .i_Score(score), .i_Bird_Y(bird_y),
        .i_Dead(dead), .i_Start(start), .i_TX_Active(tx_active), .i_TX_Done(tx_done),
        .o_TX_DV(dv), .o_TX_Byte(tx_byte), .o_Busy(busy), .o_Pkt_Done(done_p),
        .o_Error(err), .o_Drop_Count(drops)
    );

    score_packet_tx #(.HEADER(8'hA5), .Y_WIDTH(10), .TIMEOUT_CLKS(20)) dut2 (
        .i_Clk(clk), .i_Reset(rst), .i_Send(send2), .i_Score(score), .i_Bird_Y(bird_y),
        .i_Dead(dead), .i_Start(start), .i_TX_Active(act2), .i_TX_Done(done2),
        .o_TX_DV(dv2), .o_TX_Byte(byte2), .o_Busy(busy2), .o_Pkt_Done(pdone2),
        .o_Error(err2), .o_Drop_Count(drops2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int idx, input logic [15:0] s,
                                              input logic [9:0] y, input logic st,
                                              input logic dd);
        logic [7:0] b [7];
        b[0] = 8'hA5;
        b[1] = s[15:8];
        b[2] = s[7:0];
        b[3] = {6'b0, y[9:8]};
        b[4] = y[7:0];
        b[5] = {6'b0, st, dd};
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        return b[idx];
    endfunction

    task automatic push_model();
        for (int i = 0; i < 7; i++) exp_q.push_back(model_byte(i, score, bird_y, start, dead));
    endtask

    task automatic pulse_send();
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_pkt_done(input string tag);
        int lim = 7 * (10 * bit_clks + 3) + 100;
        for (int i = 0; i < lim && !done_p; i++) tick();
        check(tag, done_p, 1);
    endtask

    // UART_TX model for dut: 10 bit times per byte, Done pulse as Active drops.
    initial begin
        model_act = 1'b0;
        tx_done   = 1'b0;
        forever begin
            tick();
            if (dv) begin
                model_act = 1'b1;
                repeat (10 * bit_clks) tick();
                model_act = 1'b0;
                tx_done   = 1'b1;
                tick();
                tx_done   = 1'b0;
            end
        end
    end

    // Scoreboard: every strobe must match the next queued byte.
    initial begin
        logic [7:0] e;
        forever begin
            tick();
            if (dv) begin
                n_strobes++;
                $display("[TB] strobe %0d byte %02h", n_strobes, tx_byte);
                check("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_byte, e);
                end
            end
            if (done_p || err) check("done_err_exclusive", done_p & err, 0);
        end
    end

    initial begin
        #700000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_dv, saw_err;
        int base;
        rst = 1'b1; send = 1'b0; score = '0; bird_y = '0; start = 1'b0; dead = 1'b0;
        tx_hold = 1'b0; send2 = 1'b0; act2 = 1'b0; done2 = 1'b0;
        repeat (3) tick();
        check("rst_dv", dv, 0);
        check("rst_byte", tx_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_done", done_p, 0);
        check("rst_error", err, 0);
        check("rst_drops", drops, 0);
        rst = 1'b0;
        tick();

        // Nominal packet at 217 clocks/bit
        score = 16'h0123; bird_y = 10'h0F0; start = 1'b1; dead = 1'b0; bit_clks = 217;
        foreach (nominal_tbl[i]) exp_q.push_back(nominal_tbl[i]);
        pulse_send();
        check("nom_busy", busy, 1);
        wait_pkt_done("nom_pkt_done");
        check("nom_busy_end", busy, 0);
        check("nom_queue_empty", exp_q.size(), 0);
        tick();
        check("nom_pkt_done_width", done_p, 0);

        // Snapshot and drop counting
        bit_clks = 100;
        foreach (nominal_tbl[i]) exp_q.push_back(nominal_tbl[i]);
        pulse_send();
        score = 16'hFFFF;
        repeat (100) tick();
        repeat (3) begin send = 1'b1; tick(); send = 1'b0; tick(); end
        check("drop_3", drops, 3);
        repeat (300) begin send = 1'b1; tick(); send = 1'b0; tick(); end
        check("drop_saturated", drops, 255);
        check("drop_still_busy", busy, 1);
        wait_pkt_done("snap_pkt_done");
        check("snap_queue_empty", exp_q.size(), 0);
        check("drop_after_pkt", drops, 255);

        // Reset during byte index 4
        bit_clks = 20; score = 16'hBEEF; bird_y = 10'h2AB; start = 1'b0; dead = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(model_byte(i, score, bird_y, start, dead));
        base = n_strobes;
        pulse_send();
        for (int i = 0; i < 2000 && n_strobes < base + 5; i++) tick();
        check("rst_mid_reached_byte4", n_strobes - base, 5);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_dv", dv, 0);
        check("rst_mid_byte", tx_byte, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pkt_done", done_p, 0);
        check("rst_mid_error", err, 0);
        check("rst_mid_drops", drops, 0);
        repeat (300) tick();
        check("rst_mid_idle", busy, 0);
        check("rst_mid_queue_empty", exp_q.size(), 0);
        push_model();
        pulse_send();
        wait_pkt_done("rst_next_pkt_done");
        check("rst_next_queue_empty", exp_q.size(), 0);
        tick();

        // UART busy before first byte, then back-to-back packets
        bit_clks = 4; score = 16'h1357; bird_y = 10'h155; start = 1'b1; dead = 1'b1;
        tx_hold = 1'b1;
        push_model();
        pulse_send();
        saw_dv = 1'b0;
        repeat (50) begin tick(); saw_dv |= dv; end
        check("hold_no_dv", saw_dv, 0);
        tx_hold = 1'b0;
        check("hold_dv_at_fall", dv, 0);
        tick();
        check("hold_dv_after_fall", dv, 1);
        wait_pkt_done("b2b_first_done");
        score = 16'h2468; bird_y = 10'h3C3; start = 1'b0; dead = 1'b0;
        push_model();
        pulse_send();
        check("b2b_busy", busy, 1);
        check("b2b_drops", drops, 0);
        wait_pkt_done("b2b_second_done");
        check("b2b_drops_end", drops, 0);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Timeout on the 20-clock instance: no Done after byte 2
        score = 16'h0A0B; bird_y = 10'h10C; start = 1'b1; dead = 1'b0;
        send2 = 1'b1;
        tick();
        send2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20 && !dv2; i++) tick();
            check($sformatf("to_dv%0d", k), dv2, 1);
            check($sformatf("to_byte%0d", k), byte2, model_byte(k, score, bird_y, start, dead));
            $display("[TB] timeout-dut strobe %0d byte %02h", k, byte2);
            if (k < 2) begin
                repeat (5) tick();
                done2 = 1'b1;
                tick();
                done2 = 1'b0;
            end
        end
        saw_dv = 1'b0;
        saw_err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            saw_dv |= dv2;
            if (i < 20) saw_err |= err2;
        end
        check("to_error_at_20", err2, 1);
        check("to_error_not_early", saw_err, 0);
        check("to_busy_low", busy2, 0);
        check("to_no_pkt_done", pdone2, 0);
        check("to_no_dv_in_wait", saw_dv, 0);
        saw_dv = 1'b0;
        repeat (30) begin tick(); saw_dv |= dv2; end
        check("to_no_4th_strobe", saw_dv, 0);
        send2 = 1'b1;
        tick();
        send2 = 1'b0;
        for (int i = 0; i < 20 && !dv2; i++) tick();
        check("to_fresh_dv", dv2, 1);
        check("to_fresh_header", byte2, 8'hA5);
        check("to_drops", drops2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
